// File: rtl/pipeline_stall_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard stalls, taken
// branches and multi-cycle memory freezes into per-stage enables/flushes.
module pipeline_stall_sequencer #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hz_stall,
    input  logic             br_taken,
    input  logic             mem_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam bit         MEM_FREEZE = (MEM_LATENCY > 1);
    localparam logic [3:0] LAT_M1     = 4'(MEM_LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    logic [3:0] cnt;
    logic       freeze;

    // The RUN cycle that sees mem_req is itself the first freeze cycle.
    always_comb begin
        freeze = 1'b0;
        if (!reset) begin
            if (state == RUN)
                freeze = mem_req && MEM_FREEZE;
            else
                freeze = (cnt > 4'd1);
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_flush = 1'b0;
        busy         = 1'b0;
        if (reset) begin
            // idle set while reset is held
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
            busy         = 1'b1;
        end else if (hz_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (br_taken) begin
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && MEM_FREEZE) begin
                        state <= MEM_WAIT;
                        cnt   <= LAT_M1;
                    end
                end
                MEM_WAIT: begin
                    // mem_req is ignored here; the release cycle advances the pipeline.
                    if (cnt > 4'd1) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= RUN;
                        cnt   <= 4'd0;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (!pc_write && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + 1'b1;
            if (if_id_flush && flush_cycles != CNT_MAX)
                flush_cycles <= flush_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Randomized and directed bench for pipeline_stall_sequencer with a
// cycle-level reference model based on memory-access occupancy position.
module tb_pipeline_stall_sequencer;

    localparam int LAT   = 3;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush, busy}
    localparam logic [7:0] O_IDLE   = 8'b1101_0100;
    localparam logic [7:0] O_FREEZE = 8'b0000_0011;
    localparam logic [7:0] O_STALL  = 8'b0001_1100;
    localparam logic [7:0] O_FLUSH  = 8'b1111_0100;

    logic clk;
    logic reset, hz_stall, br_taken, mem_req;
    logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic ex_mem_write, mem_wb_flush, busy;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model: position of the cycle within the current memory access
    // (-1 when no access is in flight), plus plain integer counters.
    int pos = -1;
    int m_stall = 0;
    int m_flush = 0;
    bit cnt_known = 0;

    pipeline_stall_sequencer #(.MEM_LATENCY(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .hz_stall(hz_stall), .br_taken(br_taken),
        .mem_req(mem_req), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_write(id_ex_write),
        .id_ex_flush(id_ex_flush), .ex_mem_write(ex_mem_write),
        .mem_wb_flush(mem_wb_flush), .busy(busy),
        .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_out(input logic r, input logic h,
                                             input logic b, input logic m);
        if (r) return O_IDLE;
        if (pos >= 0 && pos < LAT - 1) return O_FREEZE;
        if (pos < 0 && m && LAT > 1) return O_FREEZE;
        if (h) return O_STALL;
        if (b) return O_FLUSH;
        return O_IDLE;
    endfunction

    task automatic model_update(input logic r, input logic m, input logic [7:0] o);
        if (r) begin
            pos = -1;
            m_stall = 0;
            m_flush = 0;
            cnt_known = 1;
        end else begin
            if (pos >= 0) pos = (pos == LAT - 1) ? -1 : pos + 1;
            else if (m && LAT > 1) pos = 1;
            if (!o[7] && m_stall < CMAX) m_stall++;
            if (o[5] && m_flush < CMAX) m_flush++;
        end
    endtask

    task automatic step(input logic r, input logic h, input logic b, input logic m);
        logic [7:0] e;
        reset = r; hz_stall = h; br_taken = b; mem_req = m;
        @(negedge clk);
        e = model_out(r, h, b, m);
        check("stage_outputs", {24'd0, pc_write, if_id_write, if_id_flush, id_ex_write,
                                id_ex_flush, ex_mem_write, mem_wb_flush, busy}, {24'd0, e});
        if (cnt_known) begin
            check("stall_cycles", {16'd0, stall_cycles}, m_stall);
            check("flush_cycles", {16'd0, flush_cycles}, m_flush);
        end
        model_update(r, m, e);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_counters(input string tag, input int s, input int f);
        check({tag, "_stall"}, {16'd0, stall_cycles}, s);
        check({tag, "_flush"}, {16'd0, flush_cycles}, f);
    endtask

    initial begin
        // Reset held with every request asserted: idle set throughout.
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1);
        expect_counters("after_reset", 0, 0);

        // Memory access: freeze, freeze, release.
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        expect_counters("mem_access", 2, 0);

        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        expect_counters("hz_single", 1, 0);

        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);
        expect_counters("hz_beats_br", 1, 1);

        // Hazard held through both freeze cycles and the release cycle.
        step(1, 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        expect_counters("hz_in_freeze", 3, 0);

        step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end

        // Reset landing in MEM_WAIT with two cycles still to go.
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        expect_counters("reset_mid_wait", 0, 0);

        for (int i = 0; i < 70000; i++) step(0, 1, 0, 0);
        expect_counters("saturate", CMAX, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_sequencer.md
# pipeline_stall_sequencer

Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges the combinational load-use/branch stall request from the hazard unit, the ID-stage branch-taken signal and multi-cycle data-memory accesses into one coherent set of per-stage write enables and flushes. It also keeps saturating performance counters for stall and flush cycles. Sits beside the hazard unit and drives the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- MEM_LATENCY, 2, cycles one data-memory access occupies the MEM stage; legal 1..15; 1 disables memory freezes.
- CNT_W, 16, width of performance counters.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- hz_stall  in  1  hazard-unit stall request (load-use or branch operand hazard).
- br_taken  in  1  branch in ID resolved taken.
- mem_req  in  1  instruction in MEM is a load or store (MemRead|MemWrite).
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear to bubble.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX control fields cleared to zero.
- ex_mem_write  out  1  EX/MEM load enable.
- mem_wb_flush  out  1  MEM/WB control fields cleared to zero.
- busy  out  1  memory freeze in progress.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0.
- flush_cycles  out  CNT_W  count of cycles with if_id_flush=1.

## Operation
- Idle output set: all *_write=1, all *_flush=0, busy=0.
- States: RUN, MEM_WAIT; 4-bit down-counter cnt.
- Freeze output set: pc_write=if_id_write=id_ex_write=ex_mem_write=0, if_id_flush=id_ex_flush=0, mem_wb_flush=1, busy=1.
- Normal evaluation (priority high->low):
  - hz_stall=1 -> pc_write=0, if_id_write=0, id_ex_flush=1; br_taken ignored this cycle.
  - br_taken=1 -> if_id_flush=1.
  - otherwise -> idle set.
- RUN:
  - mem_req=1 and MEM_LATENCY>1 -> freeze set; cnt<=MEM_LATENCY-1; next MEM_WAIT.
  - otherwise -> normal evaluation; stay RUN.
- MEM_WAIT:
  - cnt>1 -> freeze set; cnt<=cnt-1.
  - cnt==1 (release) -> normal evaluation; next RUN; cnt<=0.
  - mem_req ignored throughout MEM_WAIT.
  - hz_stall and br_taken are ignored during freeze cycles and honoured on the release cycle.
- The pipeline advances on the release cycle, so mem_req sampled in the following RUN cycle belongs to the next instruction; back-to-back memory ops each freeze.
- Counters: stall_cycles += 1 each cycle pc_write=0; flush_cycles += 1 each cycle if_id_flush=1; both saturate at 2^CNT_W-1.

## Timing
- Stage outputs are combinational (Mealy) from state, cnt, hz_stall, br_taken, mem_req; zero-cycle latency.
- busy is a function of state/cnt/mem_req only.
- Counters are registered; they reflect a cycle's outputs after the next rising edge.
- A memory access freezes the pipeline for exactly MEM_LATENCY-1 cycles; total MEM occupancy is MEM_LATENCY cycles.
- Reset, applied any cycle including mid-MEM_WAIT:
  - while asserted, outputs take the idle set and inputs are ignored;
  - at the edge: state=RUN, cnt=0, stall_cycles=0, flush_cycles=0;
  - first cycle after deassertion evaluates in RUN.
- Simultaneous events:
  - mem_req beats hz_stall/br_taken in RUN;
  - hz_stall beats br_taken;
  - reset beats all.

## Test plan
- Reset: hold reset 3 cycles with hz_stall=br_taken=mem_req=1 -> idle output set every cycle, counters 0 after release.
- MEM_LATENCY=3, mem_req=1 for 3 cycles from RUN -> freeze, freeze, release (pc_write 0,0,1; mem_wb_flush 1,1,0; busy 1,1,0); stall_cycles=2.
- hz_stall=1 one cycle in RUN -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle only; stall_cycles=1.
- hz_stall=br_taken=1, then br_taken alone -> cycle 1 if_id_flush=0, id_ex_flush=1; cycle 2 if_id_flush=1; flush_cycles=1, stall_cycles=1.
- MEM_LATENCY=3, hz_stall=1 during both freeze cycles and the release cycle -> freeze set twice, stall set on release; stall_cycles=3.
- Reset asserted in MEM_WAIT with cnt=2 -> next cycle RUN with idle set (mem_req=0); counters 0. Then hold hz_stall 70000 cycles -> stall_cycles=0xFFFF.
